ibex_instr_bus_arbiter: RTL

- Two-master, one-slave arbiter for the Ibex instruction-fetch bus (req/gnt address phase, rvalid/rdata/err response phase).
- Lets the core fetch port (m0) and a secondary fetcher (m1, e.g. boot/debug loader) share one instruction memory port (s).
- Address phase is round-robin with a hold lock. In-order responses are routed back through an ID FIFO of outstanding grants.
- Combinational pass-through: zero added latency on both phases.

---
 rtl/ibex_instr_bus_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/ibex_instr_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ibex_instr_bus_arbiter: two-master round-robin instruction-bus arbiter,  |
// | in-order response routing through an ID FIFO.   Revision: 1.0            |
// +--------------------------------------------------------------------------+
module ibex_instr_bus_arbiter #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic        s_req,
  output logic [31:0] s_addr,
  input  logic        s_gnt,
  input  logic        s_rvalid,
  input  logic        s_err,
  input  logic [31:0] s_rdata,
  output logic        spurious_rvalid
);

  localparam int C_PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int C_CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [C_CNT_W-1:0] C_MAX_CNT  = C_CNT_W'(MAX_OUTSTANDING);
  localparam logic [C_PTR_W-1:0] C_LAST_PTR = C_PTR_W'(MAX_OUTSTANDING - 1);

  logic [C_CNT_W-1:0] count_q, count_d;
  logic [C_PTR_W-1:0] wptr_q, wptr_d;
  logic [C_PTR_W-1:0] rptr_q, rptr_d;
  logic               id_q [MAX_OUTSTANDING];
  logic               lock_q, lock_d;
  logic               locked_sel_q, locked_sel_d;
  logic               last_q, last_d;
  logic               spurious_q, spurious_d;

  logic w_sel;
  logic w_sel_req;
  logic w_not_full;
  logic w_push;
  logic w_pop;
  logic w_head;

  // Lock wins; a lone requester wins; a tie goes to the master not granted last.
  always_comb begin
    w_sel = ~last_q;
    if (lock_q) begin
      w_sel = locked_sel_q;
    end else if (m0_req ^ m1_req) begin
      w_sel = m1_req;
    end
  end

  assign w_sel_req  = w_sel ? m1_req : m0_req;
  assign w_not_full = (count_q < C_MAX_CNT);
  assign s_req      = w_sel_req & w_not_full;
  assign s_addr     = w_sel ? m1_addr : m0_addr;
  assign w_push     = s_req & s_gnt;
  assign m0_gnt     = w_push & ~w_sel;
  assign m1_gnt     = w_push & w_sel;

  assign w_pop     = s_rvalid & (count_q != '0);
  assign w_head    = id_q[rptr_q];
  assign m0_rvalid = w_pop & ~w_head;
  assign m1_rvalid = w_pop & w_head;
  assign m0_err    = w_pop & ~w_head & s_err;
  assign m1_err    = w_pop & w_head & s_err;
  assign m0_rdata  = s_rdata;
  assign m1_rdata  = s_rdata;

  assign spurious_rvalid = spurious_q;

  always_comb begin
    count_d      = count_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    last_d       = last_q;
    locked_sel_d = locked_sel_q;
    // Holding the request steady until granted; a dropped req releases it.
    lock_d       = s_req & ~s_gnt;
    spurious_d   = spurious_q | (s_rvalid & (count_q == '0));

    if (s_req & ~s_gnt) begin
      locked_sel_d = w_sel;
    end
    if (w_push) begin
      last_d = w_sel;
      wptr_d = (wptr_q == C_LAST_PTR) ? '0 : wptr_q + 1'b1;
    end
    if (w_pop) begin
      rptr_d = (rptr_q == C_LAST_PTR) ? '0 : rptr_q + 1'b1;
    end
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      lock_q       <= 1'b0;
      locked_sel_q <= 1'b0;
      last_q       <= 1'b1;
      spurious_q   <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        id_q[i] <= 1'b0;
      end
    end else begin
      count_q      <= count_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      lock_q       <= lock_d;
      locked_sel_q <= locked_sel_d;
      last_q       <= last_d;
      spurious_q   <= spurious_d;
      if (w_push) begin
        id_q[wptr_q] <= w_sel;
      end
    end
  end

endmodule
`default_nettype wire
